spi_periph_bridge: RTL and testbench
====================================

Name: spi_periph_bridge

Overview:
- Sits directly downstream of the SPI register front-end in the test harness. It converts completed SPI register transactions into peripheral-bus accesses for the block under test.
- Writes are issued as single-cycle write strobes.
- Reads are issued as held read strobes. The block waits for the peripheral's ready, then returns width-masked data with a one-cycle valid pulse back to the SPI front-end.

Parameters:
ADDR_W, 6, peripheral address width (matches the SPI front-end address field)
DATA_W, 32, data width (matches the SPI front-end register width)
TIMEOUT_CYCLES, 255, maximum READ cycles before a read is abandoned; must be at least 1

Ports:
clk  input  1  system clock
rstb  input  1  reset, asynchronous, active-low
ena  input  1  clock enable; all state frozen while low
reg_addr  input  ADDR_W  transaction address from the SPI front-end
reg_rw  input  1  1=write, 0=read
txn_width  input  2  00 byte, 01 half, 10 word, 11 none
reg_addr_v  input  1  read request; held high by the SPI front-end until reg_data_i_dv
reg_data_o  input  DATA_W  write data from the SPI front-end
reg_data_o_dv  input  1  write data valid, one-cycle pulse
reg_data_i  output  DATA_W  read data returned to the SPI front-end
reg_data_i_dv  output  1  read data valid, one-cycle pulse
per_addr  output  ADDR_W  peripheral address
per_data_in  output  DATA_W  write data to the peripheral
per_write_n  output  2  write strobe: width code when active, 11 when idle
per_read_n  output  2  read strobe: width code when active, 11 when idle
per_data_out  input  DATA_W  peripheral read data
per_data_ready  input  1  peripheral read complete
timeout_err  output  1  set when a read times out; cleared when the next read is accepted

Behaviour:
- Clock and reset: one clock, clk. Reset rstb is asynchronous, active-low. All outputs are registered.
- Reset values: per_write_n=11, per_read_n=11, per_addr=0, per_data_in=0, reg_data_i=0, reg_data_i_dv=0, timeout_err=0, state=IDLE, timeout counter=0.
- ena low: no state, counter or output change; pulses stretch accordingly.
- States: IDLE, WRITE, READ, RESP, HOLD.
- IDLE, write request:
  - Condition: reg_data_o_dv=1, reg_rw=1 and txn_width!=11.
  - Latch reg_addr into per_addr, reg_data_o into per_data_in, txn_width into per_write_n; go to WRITE.
  - If txn_width=11, the write is dropped and the block stays in IDLE.
- WRITE: per_write_n is active for exactly one cycle (request at cycle N, strobe at N+1); then per_write_n returns to 11 and the block goes to IDLE.
- IDLE, read request:
  - Condition: reg_addr_v=1 and reg_rw=0.
  - Latch reg_addr into per_addr; clear timeout_err.
  - If txn_width!=11: set per_read_n=txn_width, clear the counter, go to READ.
  - If txn_width=11: load reg_data_i=0 and go to RESP with no bus access.
- READ:
  - per_read_n is held at the width code, and per_data_ready is sampled every enabled cycle.
  - On per_data_ready=1: capture the masked per_data_out into reg_data_i, set per_read_n=11, go to RESP. Ready may arrive in the first READ cycle.
  - Otherwise the counter increments. When the counter reaches TIMEOUT_CYCLES-1 without ready: reg_data_i=all-ones, timeout_err=1, per_read_n=11, go to RESP.
- Masking:
  - byte: zero-extend per_data_out[7:0]
  - half: zero-extend per_data_out[15:0]
  - word: full per_data_out
- RESP: reg_data_i_dv=1 for exactly one cycle, with reg_data_i stable in that same cycle. Go to HOLD.
- HOLD: wait until reg_addr_v=0, then go to IDLE. This prevents a still-high reg_addr_v from re-triggering a read.
- Simultaneous write and read request in IDLE: the write wins; the read is taken after the write completes, provided reg_addr_v is still high.
- Write pulse outside IDLE: silently dropped.
- Latency:
  - write: dv at N gives strobe at N+1
  - read, ready at first READ cycle: request at N gives reg_data_i_dv at N+2
  - read, timeout: reg_data_i_dv at N+TIMEOUT_CYCLES+1
- Reset mid-operation: immediate return to reset values; any strobe in flight is aborted.

Decomposition:
- Shared package spi_bridge_pkg:
  - width codes WIDTH_BYTE=2'b00, WIDTH_HALF=2'b01, WIDTH_WORD=2'b10, WIDTH_NONE=2'b11
  - state enum bridge_state_t
  - default TIMEOUT_CYCLES
- One sub-module: bus_width_mask, a combinational read-data masker (width code, raw data -> masked data), reusable by other harness blocks.

Test Plan:
- Word write, addr 0x05, data 0xA5A5_1234 -> one cycle of per_write_n=10, per_addr=0x05, per_data_in=0xA5A5_1234, then per_write_n returns to 11.
- Byte read, addr 0x02, peripheral returns 0xDEAD_BE7F with ready 3 cycles after the strobe -> per_read_n=00 held for 3 cycles; reg_data_i_dv for 1 cycle with reg_data_i=0x0000_007F.
- Half read with ready in the same cycle as the strobe -> reg_data_i_dv 2 cycles after the request; reg_data_i=lower 16 bits only; reg_addr_v held 2 more cycles; no second strobe.
- Read where ready never comes, TIMEOUT_CYCLES=4 -> per_read_n active for 4 cycles; reg_data_i=0xFFFF_FFFF; timeout_err=1. A following good read clears timeout_err.
- txn_width=11 read and write -> no strobes at all; read returns reg_data_i=0 with one dv pulse; write changes nothing.
- ena low for 5 cycles during READ, plus rstb asserted mid-READ -> no state advance while ena is low; after reset, per_read_n=11, reg_data_i_dv=0, state IDLE.

Source files
------------

// File: rtl/spi_bridge_pkg.sv
// Shared definitions for the SPI register front-end to peripheral-bus bridge.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package spi_bridge_pkg;

  // Transaction width codes, shared by the SPI front-end and the peripheral strobes
  localparam logic [1:0] WIDTH_BYTE = 2'b00;
  localparam logic [1:0] WIDTH_HALF = 2'b01;
  localparam logic [1:0] WIDTH_WORD = 2'b10;
  localparam logic [1:0] WIDTH_NONE = 2'b11;

  localparam int DEFAULT_TIMEOUT_CYCLES = 255;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ,
    ST_RESP,
    ST_HOLD
  } bridge_state_t;

endpackage

// File: rtl/bus_width_mask.sv
// Zero-extends raw peripheral read data to the requested transaction width.
// Latency: combinational, zero cycles.
// Backpressure: none; output follows inputs directly.
module bus_width_mask
  import spi_bridge_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [1:0]        width_code,
  input  logic [DATA_W-1:0] data_raw,
  output logic [DATA_W-1:0] data_masked
);

  // Keep only the lanes covered by the width code; NONE yields zero
  always_comb begin
    data_masked = '0;
    case (width_code)
      WIDTH_BYTE: data_masked[7:0]  = data_raw[7:0];
      WIDTH_HALF: data_masked[15:0] = data_raw[15:0];
      WIDTH_WORD: data_masked       = data_raw;
      default:    data_masked       = '0;
    endcase
  end

endmodule

// File: rtl/spi_periph_bridge.sv
// Turns completed SPI register transactions into peripheral write/read strobes.
// Latency: write strobe 1 cycle after dv; read dv 2 cycles after request at best, TIMEOUT_CYCLES+1 worst.
// Backpressure: reads wait on per_data_ready (bounded by timeout); writes outside IDLE are dropped.
module spi_periph_bridge
  import spi_bridge_pkg::*;
#(
  parameter int ADDR_W         = 6,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic              clk,
  input  logic              rstb,
  input  logic              ena,
  input  logic [ADDR_W-1:0] reg_addr,
  input  logic              reg_rw,
  input  logic [1:0]        txn_width,
  input  logic              reg_addr_v,
  input  logic [DATA_W-1:0] reg_data_o,
  input  logic              reg_data_o_dv,
  output logic [DATA_W-1:0] reg_data_i,
  output logic              reg_data_i_dv,
  output logic [ADDR_W-1:0] per_addr,
  output logic [DATA_W-1:0] per_data_in,
  output logic [1:0]        per_write_n,
  output logic [1:0]        per_read_n,
  input  logic [DATA_W-1:0] per_data_out,
  input  logic              per_data_ready,
  output logic              timeout_err
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  bridge_state_t     state;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] rd_masked;

  // per_read_n holds the active width code for the whole READ state,
  // so it doubles as the mask selector
  bus_width_mask #(
    .DATA_W (DATA_W)
  ) u_mask (
    .width_code  (per_read_n),
    .data_raw    (per_data_out),
    .data_masked (rd_masked)
  );

  // Bridge FSM: all outputs registered, everything frozen while ena is low
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      per_addr      <= '0;
      per_data_in   <= '0;
      per_write_n   <= WIDTH_NONE;
      per_read_n    <= WIDTH_NONE;
      reg_data_i    <= '0;
      reg_data_i_dv <= 1'b0;
      timeout_err   <= 1'b0;
    end else if (ena) begin
      case (state)
        ST_IDLE: begin
          // a write pulse takes priority; a held read request is picked up afterwards
          if (reg_data_o_dv && reg_rw) begin
            if (txn_width != WIDTH_NONE) begin
              per_addr    <= reg_addr;
              per_data_in <= reg_data_o;
              per_write_n <= txn_width;
              state       <= ST_WRITE;
            end
          end else if (reg_addr_v && !reg_rw) begin
            per_addr    <= reg_addr;
            timeout_err <= 1'b0;
            if (txn_width != WIDTH_NONE) begin
              per_read_n <= txn_width;
              cnt        <= '0;
              state      <= ST_READ;
            end else begin
              reg_data_i    <= '0;
              reg_data_i_dv <= 1'b1;
              state         <= ST_RESP;
            end
          end
        end
        ST_WRITE: begin
          per_write_n <= WIDTH_NONE;
          state       <= ST_IDLE;
        end
        ST_READ: begin
          if (per_data_ready) begin
            reg_data_i    <= rd_masked;
            per_read_n    <= WIDTH_NONE;
            reg_data_i_dv <= 1'b1;
            state         <= ST_RESP;
          end else if (cnt == CNT_LAST) begin
            reg_data_i    <= '1;
            timeout_err   <= 1'b1;
            per_read_n    <= WIDTH_NONE;
            reg_data_i_dv <= 1'b1;
            state         <= ST_RESP;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_RESP: begin
          reg_data_i_dv <= 1'b0;
          state         <= ST_HOLD;
        end
        ST_HOLD: begin
          // wait for the front-end to drop its request so it cannot re-trigger
          if (!reg_addr_v) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_periph_bridge.sv
// Directed self-checking bench for spi_periph_bridge.
// Latency: n/a.
// Backpressure: n/a.
module tb_spi_periph_bridge;

  logic        clk = 1'b0;
  logic        rstb;
  logic        ena;
  logic [5:0]  reg_addr;
  logic        reg_rw;
  logic [1:0]  txn_width;
  logic        reg_addr_v;
  logic [31:0] reg_data_o;
  logic        reg_data_o_dv;
  logic [31:0] reg_data_i;
  logic        reg_data_i_dv;
  logic [5:0]  per_addr;
  logic [31:0] per_data_in;
  logic [1:0]  per_write_n;
  logic [1:0]  per_read_n;
  logic [31:0] per_data_out;
  logic        per_data_ready;
  logic        timeout_err;

  int pass_cnt  = 0;
  int total_cnt = 0;

  spi_periph_bridge #(
    .ADDR_W         (6),
    .DATA_W         (32),
    .TIMEOUT_CYCLES (4)
  ) dut (
    .clk            (clk),
    .rstb           (rstb),
    .ena            (ena),
    .reg_addr       (reg_addr),
    .reg_rw         (reg_rw),
    .txn_width      (txn_width),
    .reg_addr_v     (reg_addr_v),
    .reg_data_o     (reg_data_o),
    .reg_data_o_dv  (reg_data_o_dv),
    .reg_data_i     (reg_data_i),
    .reg_data_i_dv  (reg_data_i_dv),
    .per_addr       (per_addr),
    .per_data_in    (per_data_in),
    .per_write_n    (per_write_n),
    .per_read_n     (per_read_n),
    .per_data_out   (per_data_out),
    .per_data_ready (per_data_ready),
    .timeout_err    (timeout_err)
  );

  always #5 clk = ~clk;

  // advance to just after the next rising edge; outputs are stable there
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstb = 1'b0; ena = 1'b1; reg_addr = '0; reg_rw = 1'b0; txn_width = 2'b11;
    reg_addr_v = 1'b0; reg_data_o = '0; reg_data_o_dv = 1'b0;
    per_data_out = '0; per_data_ready = 1'b0;
    step(); step();
    total_cnt++; if (per_write_n !== 2'b11) $display("FAIL rst_write_n got=%b exp=11", per_write_n); else pass_cnt++;
    total_cnt++; if (per_read_n !== 2'b11) $display("FAIL rst_read_n got=%b exp=11", per_read_n); else pass_cnt++;
    total_cnt++; if (per_addr !== 6'd0) $display("FAIL rst_addr got=%h exp=0", per_addr); else pass_cnt++;
    total_cnt++; if (per_data_in !== 32'd0) $display("FAIL rst_data_in got=%h exp=0", per_data_in); else pass_cnt++;
    total_cnt++; if (reg_data_i !== 32'd0) $display("FAIL rst_rdata got=%h exp=0", reg_data_i); else pass_cnt++;
    total_cnt++; if (reg_data_i_dv !== 1'b0) $display("FAIL rst_dv got=%b exp=0", reg_data_i_dv); else pass_cnt++;
    total_cnt++; if (timeout_err !== 1'b0) $display("FAIL rst_tmo got=%b exp=0", timeout_err); else pass_cnt++;
    rstb = 1'b1;
    step();
  endtask

  task automatic test_word_write();
    reg_rw = 1'b1; txn_width = 2'b10; reg_addr = 6'h05;
    reg_data_o = 32'hA5A5_1234; reg_data_o_dv = 1'b1;
    step();
    reg_data_o_dv = 1'b0;
    total_cnt++; if (per_write_n !== 2'b10) $display("FAIL wr_strobe got=%b exp=10", per_write_n); else pass_cnt++;
    total_cnt++; if (per_addr !== 6'h05) $display("FAIL wr_addr got=%h exp=05", per_addr); else pass_cnt++;
    total_cnt++; if (per_data_in !== 32'hA5A5_1234) $display("FAIL wr_data got=%h exp=a5a51234", per_data_in); else pass_cnt++;
    total_cnt++; if (per_read_n !== 2'b11) $display("FAIL wr_no_read got=%b exp=11", per_read_n); else pass_cnt++;
    step();
    total_cnt++; if (per_write_n !== 2'b11) $display("FAIL wr_release got=%b exp=11", per_write_n); else pass_cnt++;
    step();
    total_cnt++; if (per_write_n !== 2'b11) $display("FAIL wr_single got=%b exp=11", per_write_n); else pass_cnt++;
  endtask

  task automatic test_byte_read();
    reg_rw = 1'b0; txn_width = 2'b00; reg_addr = 6'h02; reg_addr_v = 1'b1;
    per_data_out = 32'hDEAD_BE7F; per_data_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      total_cnt++; if (per_read_n !== 2'b00) $display("FAIL brd_strobe_c%0d got=%b exp=00", i, per_read_n); else pass_cnt++;
      total_cnt++; if (reg_data_i_dv !== 1'b0) $display("FAIL brd_early_dv_c%0d got=%b exp=0", i, reg_data_i_dv); else pass_cnt++;
    end
    total_cnt++; if (per_addr !== 6'h02) $display("FAIL brd_addr got=%h exp=02", per_addr); else pass_cnt++;
    per_data_ready = 1'b1;
    step();
    per_data_ready = 1'b0;
    total_cnt++; if (reg_data_i_dv !== 1'b1) $display("FAIL brd_dv got=%b exp=1", reg_data_i_dv); else pass_cnt++;
    total_cnt++; if (reg_data_i !== 32'h0000_007F) $display("FAIL brd_data got=%h exp=0000007f", reg_data_i); else pass_cnt++;
    total_cnt++; if (per_read_n !== 2'b11) $display("FAIL brd_release got=%b exp=11", per_read_n); else pass_cnt++;
    step();
    reg_addr_v = 1'b0;
    total_cnt++; if (reg_data_i_dv !== 1'b0) $display("FAIL brd_dv_once got=%b exp=0", reg_data_i_dv); else pass_cnt++;
    total_cnt++; if (reg_data_i !== 32'h0000_007F) $display("FAIL brd_data_hold got=%h exp=0000007f", reg_data_i); else pass_cnt++;
    step();
  endtask

  task automatic test_half_read_fast();
    reg_rw = 1'b0; txn_width = 2'b01; reg_addr = 6'h11; reg_addr_v = 1'b1;
    per_data_out = 32'h1234_ABCD; per_data_ready = 1'b1;
    step();
    total_cnt++; if (per_read_n !== 2'b01) $display("FAIL hrd_strobe got=%b exp=01", per_read_n); else pass_cnt++;
    total_cnt++; if (reg_data_i_dv !== 1'b0) $display("FAIL hrd_early_dv got=%b exp=0", reg_data_i_dv); else pass_cnt++;
    step();
    total_cnt++; if (reg_data_i_dv !== 1'b1) $display("FAIL hrd_dv got=%b exp=1", reg_data_i_dv); else pass_cnt++;
    total_cnt++; if (reg_data_i !== 32'h0000_ABCD) $display("FAIL hrd_data got=%h exp=0000abcd", reg_data_i); else pass_cnt++;
    for (int i = 0; i < 2; i++) begin
      step();
      total_cnt++; if (per_read_n !== 2'b11) $display("FAIL hrd_no_restrobe_c%0d got=%b exp=11", i, per_read_n); else pass_cnt++;
      total_cnt++; if (reg_data_i_dv !== 1'b0) $display("FAIL hrd_no_redv_c%0d got=%b exp=0", i, reg_data_i_dv); else pass_cnt++;
    end
    reg_addr_v = 1'b0; per_data_ready = 1'b0;
    step();
    total_cnt++; if (per_read_n !== 2'b11) $display("FAIL hrd_idle got=%b exp=11", per_read_n); else pass_cnt++;
  endtask

  task automatic test_timeout();
    reg_rw = 1'b0; txn_width = 2'b10; reg_addr = 6'h3F; reg_addr_v = 1'b1;
    per_data_out = 32'h0BAD_0BAD; per_data_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      total_cnt++; if (per_read_n !== 2'b10) $display("FAIL tmo_strobe_c%0d got=%b exp=10", i, per_read_n); else pass_cnt++;
    end
    step();
    total_cnt++; if (per_read_n !== 2'b11) $display("FAIL tmo_release got=%b exp=11", per_read_n); else pass_cnt++;
    total_cnt++; if (reg_data_i_dv !== 1'b1) $display("FAIL tmo_dv got=%b exp=1", reg_data_i_dv); else pass_cnt++;
    total_cnt++; if (reg_data_i !== 32'hFFFF_FFFF) $display("FAIL tmo_data got=%h exp=ffffffff", reg_data_i); else pass_cnt++;
    total_cnt++; if (timeout_err !== 1'b1) $display("FAIL tmo_err got=%b exp=1", timeout_err); else pass_cnt++;
    reg_addr_v = 1'b0;
    step();
    total_cnt++; if (timeout_err !== 1'b1) $display("FAIL tmo_err_sticky got=%b exp=1", timeout_err); else pass_cnt++;
    step();
    // a following good read clears the error flag when accepted
    txn_width = 2'b10; reg_addr = 6'h21; reg_addr_v = 1'b1;
    per_data_out = 32'hCAFE_F00D; per_data_ready = 1'b1;
    step();
    total_cnt++; if (timeout_err !== 1'b0) $display("FAIL tmo_err_clear got=%b exp=0", timeout_err); else pass_cnt++;
    step();
    total_cnt++; if (reg_data_i !== 32'hCAFE_F00D) $display("FAIL tmo_next_data got=%h exp=cafef00d", reg_data_i); else pass_cnt++;
    reg_addr_v = 1'b0; per_data_ready = 1'b0;
    step(); step();
  endtask

  task automatic test_width_none();
    reg_rw = 1'b0; txn_width = 2'b11; reg_addr = 6'h0C; reg_addr_v = 1'b1;
    step();
    total_cnt++; if (per_read_n !== 2'b11) $display("FAIL none_rd_strobe got=%b exp=11", per_read_n); else pass_cnt++;
    total_cnt++; if (reg_data_i_dv !== 1'b1) $display("FAIL none_rd_dv got=%b exp=1", reg_data_i_dv); else pass_cnt++;
    total_cnt++; if (reg_data_i !== 32'd0) $display("FAIL none_rd_data got=%h exp=0", reg_data_i); else pass_cnt++;
    total_cnt++; if (per_addr !== 6'h0C) $display("FAIL none_rd_addr got=%h exp=0c", per_addr); else pass_cnt++;
    reg_addr_v = 1'b0;
    step();
    total_cnt++; if (reg_data_i_dv !== 1'b0) $display("FAIL none_rd_dv_once got=%b exp=0", reg_data_i_dv); else pass_cnt++;
    step();
    reg_rw = 1'b1; txn_width = 2'b11; reg_addr = 6'h07;
    reg_data_o = 32'h1111_2222; reg_data_o_dv = 1'b1;
    step();
    reg_data_o_dv = 1'b0;
    total_cnt++; if (per_write_n !== 2'b11) $display("FAIL none_wr_strobe got=%b exp=11", per_write_n); else pass_cnt++;
    total_cnt++; if (per_data_in !== 32'hA5A5_1234) $display("FAIL none_wr_data got=%h exp=a5a51234", per_data_in); else pass_cnt++;
    total_cnt++; if (per_addr !== 6'h0C) $display("FAIL none_wr_addr got=%h exp=0c", per_addr); else pass_cnt++;
    step();
    total_cnt++; if (per_write_n !== 2'b11) $display("FAIL none_wr_late got=%b exp=11", per_write_n); else pass_cnt++;
  endtask

  task automatic test_ena_and_reset();
    reg_rw = 1'b0; txn_width = 2'b00; reg_addr = 6'h0A; reg_addr_v = 1'b1;
    per_data_out = 32'h0000_0042; per_data_ready = 1'b0;
    step();
    total_cnt++; if (per_read_n !== 2'b00) $display("FAIL ena_strobe got=%b exp=00", per_read_n); else pass_cnt++;
    // ready offered while frozen must not be taken
    ena = 1'b0; per_data_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      total_cnt++; if (per_read_n !== 2'b00) $display("FAIL ena_frozen_c%0d got=%b exp=00", i, per_read_n); else pass_cnt++;
      total_cnt++; if (reg_data_i_dv !== 1'b0) $display("FAIL ena_frozen_dv_c%0d got=%b exp=0", i, reg_data_i_dv); else pass_cnt++;
    end
    ena = 1'b1; per_data_ready = 1'b0;
    step();
    total_cnt++; if (per_read_n !== 2'b00) $display("FAIL ena_resume got=%b exp=00", per_read_n); else pass_cnt++;
    rstb = 1'b0;
    #1;
    total_cnt++; if (per_read_n !== 2'b11) $display("FAIL arst_read_n got=%b exp=11", per_read_n); else pass_cnt++;
    total_cnt++; if (reg_data_i_dv !== 1'b0) $display("FAIL arst_dv got=%b exp=0", reg_data_i_dv); else pass_cnt++;
    total_cnt++; if (per_addr !== 6'd0) $display("FAIL arst_addr got=%h exp=0", per_addr); else pass_cnt++;
    reg_addr_v = 1'b0;
    step();
    rstb = 1'b1;
    step();
    // back in IDLE: a byte write is accepted straight away
    reg_rw = 1'b1; txn_width = 2'b00; reg_addr = 6'h01;
    reg_data_o = 32'h0000_0055; reg_data_o_dv = 1'b1;
    step();
    reg_data_o_dv = 1'b0;
    total_cnt++; if (per_write_n !== 2'b00) $display("FAIL arst_idle_wr got=%b exp=00", per_write_n); else pass_cnt++;
    total_cnt++; if (per_data_in !== 32'h0000_0055) $display("FAIL arst_idle_data got=%h exp=00000055", per_data_in); else pass_cnt++;
    step();
  endtask

  initial begin
    test_reset();
    test_word_write();
    test_byte_read();
    test_half_read_fast();
    test_timeout();
    test_width_none();
    test_ena_and_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
